// File: rtl/simon_kexp_arb.sv
// simon_kexp_arb: round-robin arbiter that shares one simon_kexp key expander
// between NUM_REQ round engines. It accepts a key, restarts and loads the
// expander, waits for expansion, then grants the owner exclusive read access
// until the owner releases it.
// Optional feature: define SIMON_KEXP_CACHE_EN to keep a {mode, key} tag of the
// last successful expansion. A matching request then goes straight to GRANT.
module simon_kexp_arb #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned SIMON_KEY_WIDTH = 128,
  parameter int unsigned TIMEOUT_CYCLES  = 512
) (
  input  logic                               ck,
  input  logic                               nrst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_mode,
  input  logic [NUM_REQ*SIMON_KEY_WIDTH-1:0] req_key,
  input  logic [NUM_REQ-1:0]                 req_release,
  output logic [NUM_REQ-1:0]                 req_ack,
  output logic [NUM_REQ-1:0]                 grant,
  output logic                               err,
  output logic                               kexp_nrst,
  output logic                               kexp_mode,
  output logic [SIMON_KEY_WIDTH-1:0]         kexp_key,
  output logic                               kexp_k_valid,
  input  logic                               kexp_k_ready,
  input  logic                               kexp_exp_valid
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_LOAD,
    S_WAIT,
    S_GRANT
  } state_t;

  state_t                     state, state_d;
  logic [PTR_W-1:0]           rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]           owner, owner_d;
  logic [CNT_W-1:0]           cnt, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0]         req_ack_d, grant_d;
  logic                       err_d, kexp_nrst_d, kexp_mode_d, kexp_k_valid_d;
  logic [SIMON_KEY_WIDTH-1:0] kexp_key_d;

  logic                       win_found;
  logic [PTR_W-1:0]           win_idx;
  int unsigned                cand;
  logic [SIMON_KEY_WIDTH-1:0] win_key;
  logic                       win_mode;
  logic [NUM_REQ-1:0]         win_oh, owner_oh;
  logic                       own_rel;

  assign cnt_inc = cnt + CNT_W'(1);

  // Round-robin winner: first set req_valid bit at or above rr_ptr, with wrap
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[PTR_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  // Winner payload, one-hot decodes and owner release detection
  always_comb begin
    win_key  = '0;
    win_mode = 1'b0;
    win_oh   = '0;
    owner_oh = '0;
    own_rel  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      win_oh[i]   = (win_idx == PTR_W'(i));
      owner_oh[i] = (owner == PTR_W'(i));
      own_rel     = own_rel | (owner_oh[i] & req_release[i]);
      if (win_oh[i]) begin
        win_key  = req_key[i*SIMON_KEY_WIDTH +: SIMON_KEY_WIDTH];
        win_mode = req_mode[i];
      end
    end
  end

`ifdef SIMON_KEXP_CACHE_EN
  logic                       tag_valid, tag_mode, tag_set, tag_clr, tag_hit;
  logic [SIMON_KEY_WIDTH-1:0] tag_key;

  assign tag_hit = tag_valid && (tag_mode == win_mode) && (tag_key == win_key);

  // Tag of the expansion currently parked in the expander
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      tag_valid <= 1'b0;
      tag_mode  <= 1'b0;
      tag_key   <= '0;
    end else if (tag_clr) begin
      tag_valid <= 1'b0;
    end else if (tag_set) begin
      tag_valid <= 1'b1;
      tag_mode  <= kexp_mode;
      tag_key   <= kexp_key;
    end
  end
`endif

  // Next-state and next-output logic; all outputs leave through registers
  always_comb begin
    state_d        = state;
    rr_ptr_d       = rr_ptr;
    owner_d        = owner;
    cnt_d          = cnt;
    req_ack_d      = '0;
    grant_d        = '0;
    err_d          = 1'b0;
    kexp_nrst_d    = 1'b1;
    kexp_mode_d    = kexp_mode;
    kexp_key_d     = kexp_key;
    kexp_k_valid_d = 1'b0;
`ifdef SIMON_KEXP_CACHE_EN
    tag_set        = 1'b0;
    tag_clr        = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (win_found) begin
          kexp_key_d  = win_key;
          kexp_mode_d = win_mode;
          req_ack_d   = win_oh;
          owner_d     = win_idx;
          rr_ptr_d    = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
`ifdef SIMON_KEXP_CACHE_EN
          state_d     = tag_hit ? S_GRANT : S_FLUSH;
`else
          state_d     = S_FLUSH;
`endif
        end
      end
      S_FLUSH: begin
        kexp_nrst_d = 1'b0;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        if (kexp_k_valid && kexp_k_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          kexp_k_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (kexp_exp_valid) begin
          grant_d = owner_oh;
          state_d = S_GRANT;
`ifdef SIMON_KEXP_CACHE_EN
          tag_set = 1'b1;
`endif
        end else if (cnt_inc == CNT_LAST) begin
          err_d       = 1'b1;
          kexp_nrst_d = 1'b0;
          state_d     = S_IDLE;
`ifdef SIMON_KEXP_CACHE_EN
          tag_clr     = 1'b1;
`endif
        end
      end
      S_GRANT: begin
        if (own_rel) begin
          state_d = S_IDLE;
        end else begin
          grant_d = owner_oh;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      cnt          <= '0;
      req_ack      <= '0;
      grant        <= '0;
      err          <= 1'b0;
      kexp_nrst    <= 1'b0;
      kexp_mode    <= 1'b0;
      kexp_key     <= '0;
      kexp_k_valid <= 1'b0;
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_ptr_d;
      owner        <= owner_d;
      cnt          <= cnt_d;
      req_ack      <= req_ack_d;
      grant        <= grant_d;
      err          <= err_d;
      kexp_nrst    <= kexp_nrst_d;
      kexp_mode    <= kexp_mode_d;
      kexp_key     <= kexp_key_d;
      kexp_k_valid <= kexp_k_valid_d;
    end
  end

endmodule

// File: tb/tb_simon_kexp_arb.sv
// Bench for simon_kexp_arb: the bench plays the key expander and the
// requesters, and predicts arbitration, latencies and cache hits from a
// transaction-level model (round-robin pointer and last-expanded tag).
module tb_simon_kexp_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 2;
  localparam int unsigned KW = 128;
  localparam int unsigned TO = 512;

  logic            ck = 1'b0;
  logic            nrst;
  logic [N-1:0]    req_valid, req_mode, req_release, req_ack, grant;
  logic [N*KW-1:0] req_key;
  logic            err, kexp_nrst, kexp_mode, kexp_k_valid, kexp_k_ready, kexp_exp_valid;
  logic [KW-1:0]   kexp_key;
  logic [KW-1:0]   keys [N];

  int        n_cmp = 0;
  int        n_fail = 0;
  int        m_ptr = 0;
  bit        m_tag_valid = 0;
  logic      m_tag_mode = 1'b0;
  logic [KW-1:0] m_tag_key = '0;

  always #5 ck = ~ck;

  always_comb begin
    for (int i = 0; i < N; i++) req_key[i*KW +: KW] = keys[i];
  end

  simon_kexp_arb #(.NUM_REQ(N), .SIMON_KEY_WIDTH(KW), .TIMEOUT_CYCLES(TO)) dut (
    .ck(ck), .nrst(nrst),
    .req_valid(req_valid), .req_mode(req_mode), .req_key(req_key), .req_release(req_release),
    .req_ack(req_ack), .grant(grant), .err(err),
    .kexp_nrst(kexp_nrst), .kexp_mode(kexp_mode), .kexp_key(kexp_key),
    .kexp_k_valid(kexp_k_valid), .kexp_k_ready(kexp_k_ready), .kexp_exp_valid(kexp_exp_valid)
  );

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (mask[PW'(j)]) return j;
    end
    return 0;
  endfunction

  function automatic logic [KW-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    nrst = 1'b0;
    req_valid = '0;
    req_release = '0;
    kexp_k_ready = 1'b0;
    kexp_exp_valid = 1'b0;
    step();
    nrst = 1'b1;
    m_ptr = 0;
    m_tag_valid = 0;
  endtask

  // One full transaction from an IDLE arbiter back to IDLE, checked against the model
  task automatic do_txn(input logic [N-1:0] mask, input logic [N-1:0] next_mask, input bit keep_valid,
                        input int kr_wait, input int exp_delay, input int hold);
    int w;
    logic [N-1:0] oh;
    logic [KW-1:0] e_key;
    logic e_mode;
    bit hit;
    w = rr_pick(mask, m_ptr);
    oh = N'(1) << w;
    e_key = keys[w];
    e_mode = req_mode[PW'(w)];
    req_valid = mask;
    step();
    n_cmp++;
    if (req_ack !== oh) begin n_fail++; $display("FAIL ack: got %b want %b", req_ack, oh); end
    n_cmp++;
    if (kexp_key !== e_key || kexp_mode !== e_mode) begin
      n_fail++; $display("FAIL key_latch: got %h/%b want %h/%b", kexp_key, kexp_mode, e_key, e_mode);
    end
    if (!keep_valid) req_valid = '0;
    m_ptr = (w + 1) % N;
    hit = 0;
`ifdef SIMON_KEXP_CACHE_EN
    hit = m_tag_valid && (m_tag_mode == e_mode) && (m_tag_key == e_key);
`endif
    if (hit) begin
      step();
      n_cmp++;
      if ({kexp_nrst, kexp_k_valid, grant} !== {1'b1, 1'b0, N'(0)}) begin
        n_fail++; $display("FAIL hit_gap: nrst/kv/grant %b/%b/%b want 1/0/0000", kexp_nrst, kexp_k_valid, grant);
      end
      step();
      n_cmp++;
      if ({kexp_nrst, kexp_k_valid, grant} !== {1'b1, 1'b0, oh}) begin
        n_fail++; $display("FAIL hit_grant: nrst/kv/grant %b/%b/%b want 1/0/%b", kexp_nrst, kexp_k_valid, grant, oh);
      end
    end else begin
      step();
      n_cmp++;
      if ({kexp_nrst, kexp_k_valid, grant} !== {2'b00, N'(0)}) begin
        n_fail++; $display("FAIL flush: nrst/kv/grant %b/%b/%b want 0/0/0000", kexp_nrst, kexp_k_valid, grant);
      end
      step();
      n_cmp++;
      if ({kexp_nrst, kexp_k_valid} !== 2'b11) begin
        n_fail++; $display("FAIL load: nrst/kv %b/%b want 1/1", kexp_nrst, kexp_k_valid);
      end
      for (int i = 0; i < kr_wait; i++) begin
        step();
        n_cmp++;
        if (kexp_k_valid !== 1'b1) begin n_fail++; $display("FAIL load_hold: kv %b want 1", kexp_k_valid); end
      end
      kexp_k_ready = 1'b1;
      step();
      kexp_k_ready = 1'b0;
      n_cmp++;
      if (kexp_k_valid !== 1'b0) begin n_fail++; $display("FAIL kv_drop: kv %b want 0", kexp_k_valid); end
      for (int i = 0; i < exp_delay; i++) begin
        step();
        n_cmp++;
        if (grant !== '0 || err !== 1'b0) begin
          n_fail++; $display("FAIL wait_idle: grant/err %b/%b want 0000/0", grant, err);
        end
      end
      kexp_exp_valid = 1'b1;
      step();
      kexp_exp_valid = 1'b0;
      n_cmp++;
      if (grant !== oh) begin n_fail++; $display("FAIL grant: got %b want %b", grant, oh); end
      m_tag_valid = 1;
      m_tag_mode = e_mode;
      m_tag_key = e_key;
    end
    for (int i = 0; i < hold; i++) begin
      req_release = N'($urandom) & ~oh;
      step();
      n_cmp++;
      if (grant !== oh) begin n_fail++; $display("FAIL hold: grant %b want %b", grant, oh); end
    end
    req_release = oh | (N'($urandom) & ~oh);
    req_valid = next_mask;
    step();
    req_release = '0;
    n_cmp++;
    if (grant !== '0 || req_ack !== '0) begin
      n_fail++; $display("FAIL release: grant/ack %b/%b want 0000/0000", grant, req_ack);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    req_valid = 4'b1111;
    req_mode = 4'b1111;
    req_release = '0;
    kexp_k_ready = 1'b1;
    kexp_exp_valid = 1'b0;
    for (int i = 0; i < N; i++) keys[i] = rand_key();
    step();
    step();
    n_cmp++;
    if ({req_ack, grant, err, kexp_k_valid, kexp_nrst, kexp_mode} !== {N'(0), N'(0), 4'b0000} || kexp_key !== '0) begin
      n_fail++; $display("FAIL reset_vals: ack %b grant %b err %b kv %b nrst %b mode %b key %h",
                         req_ack, grant, err, kexp_k_valid, kexp_nrst, kexp_mode, kexp_key);
    end
    req_valid = '0;
    kexp_k_ready = 1'b0;
    nrst = 1'b1;
    m_ptr = 0;
    m_tag_valid = 0;
    step();
  endtask

  task automatic test_basic();
    logic [KW-1:0] k;
    bit gbad;
    k = 128'h0f0e0d0c0b0a09080706050403020100;
    do_reset();
    keys[2] = k;
    req_mode = 4'b0100;
    req_valid = 4'b0100;
    kexp_k_ready = 1'b1;
    step();
    req_valid = '0;
    n_cmp++;
    if (req_ack !== 4'b0100 || kexp_key !== k || kexp_mode !== 1'b1) begin
      n_fail++; $display("FAIL basic_ack: ack %b key %h mode %b", req_ack, kexp_key, kexp_mode);
    end
    step();
    n_cmp++;
    if ({kexp_nrst, kexp_k_valid, req_ack} !== {2'b00, N'(0)}) begin
      n_fail++; $display("FAIL basic_flush: nrst %b kv %b ack %b want 0 0 0000", kexp_nrst, kexp_k_valid, req_ack);
    end
    step();
    n_cmp++;
    if ({kexp_nrst, kexp_k_valid} !== 2'b11) begin
      n_fail++; $display("FAIL basic_load: nrst %b kv %b want 1 1", kexp_nrst, kexp_k_valid);
    end
    step();
    kexp_k_ready = 1'b0;
    n_cmp++;
    if (kexp_k_valid !== 1'b0) begin n_fail++; $display("FAIL basic_kv_pulse: kv %b want 0", kexp_k_valid); end
    gbad = 0;
    for (int c = 4; c < 73; c++) begin
      if (grant !== '0) gbad = 1;
      step();
    end
    n_cmp++;
    if (gbad || grant !== '0) begin n_fail++; $display("FAIL basic_early_grant: grant %b want 0000", grant); end
    kexp_exp_valid = 1'b1;
    step();
    kexp_exp_valid = 1'b0;
    n_cmp++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL basic_grant: grant %b want 0100", grant); end
    step();
    step();
    req_release = 4'b0100;
    step();
    req_release = '0;
    n_cmp++;
    if (grant !== '0) begin n_fail++; $display("FAIL basic_release: grant %b want 0000", grant); end
    m_ptr = 3;
    m_tag_valid = 1;
    m_tag_mode = 1'b1;
    m_tag_key = k;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) keys[i] = rand_key();
    req_mode = N'($urandom);
    for (int t = 0; t < 5; t++) begin
      n_cmp++;
      if (m_ptr != t % N) begin n_fail++; $display("FAIL rr_ptr: model %0d want %0d", m_ptr, t % N); end
      do_txn(4'b1111, 4'b1111, 1, 0, $urandom_range(0, 10), 4);
    end
    req_valid = '0;
  endtask

  task automatic test_cache();
    logic [KW-1:0] k;
    logic m;
    do_reset();
    k = rand_key();
    m = 1'($urandom);
    keys[0] = k;
    req_mode[0] = m;
    do_txn(4'b0001, 4'b0000, 0, 1, 5, 2);
    keys[1] = k;
    req_mode[1] = m;
    do_txn(4'b0010, 4'b0000, 0, 0, 3, 2);
    keys[2] = k;
    req_mode[2] = ~m;
    do_txn(4'b0100, 4'b0000, 0, 0, 3, 1);
  endtask

  task automatic test_random_traffic();
    logic [N-1:0] cur, nxt;
    cur = N'($urandom_range(1, 15));
    for (int it = 0; it < 14; it++) begin
      for (int i = 0; i < N; i++) keys[i] = rand_key();
      req_mode = N'($urandom);
      if (m_tag_valid && ($urandom_range(0, 1) == 1)) begin
        for (int i = 0; i < N; i++) keys[i] = m_tag_key;
        req_mode = {N{m_tag_mode}};
      end
      nxt = N'($urandom_range(1, 15));
      do_txn(cur, nxt, $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(0, 4));
      cur = nxt;
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    logic [KW-1:0] old_key;
    logic old_mode;
    int k;
    bit gbad;
    old_key = m_tag_key;
    old_mode = m_tag_mode;
    keys[2] = rand_key();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    n_cmp++;
    if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL to_ack: ack %b want 0100", req_ack); end
    m_ptr = 3;
    step();
    step();
    kexp_k_ready = 1'b1;
    step();
    kexp_k_ready = 1'b0;
    k = 1;
    gbad = 0;
    while (!err && k < 600) begin
      if (grant !== '0) gbad = 1;
      step();
      k++;
    end
    n_cmp++;
    if (err !== 1'b1 || k != TO) begin n_fail++; $display("FAIL to_cycle: err %b at %0d want 1 at %0d", err, k, TO); end
    n_cmp++;
    if (kexp_nrst !== 1'b0 || grant !== '0 || gbad) begin
      n_fail++; $display("FAIL to_restart: nrst %b grant %b want 0 0000", kexp_nrst, grant);
    end
    step();
    n_cmp++;
    if ({err, kexp_nrst, grant} !== {2'b01, N'(0)}) begin
      n_fail++; $display("FAIL to_pulse: err %b nrst %b grant %b want 0 1 0000", err, kexp_nrst, grant);
    end
    m_tag_valid = 0;
    keys[0] = old_key;
    req_mode[0] = old_mode;
    do_txn(4'b0001, 4'b0000, 0, 0, 4, 1);
  endtask

  task automatic test_reset_mid();
    logic [KW-1:0] ka;
    ka = rand_key();
    keys[0] = ka;
    req_mode[0] = 1'b1;
    keys[1] = rand_key();
    do_txn(4'b0001, 4'b0000, 0, 0, 2, 1);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    n_cmp++;
    if (req_ack !== 4'b0010) begin n_fail++; $display("FAIL mid_ack: ack %b want 0010", req_ack); end
    step();
    step();
    kexp_k_ready = 1'b1;
    step();
    kexp_k_ready = 1'b0;
    step();
    step();
    kexp_exp_valid = 1'b1;
    nrst = 1'b0;
    #1;
    n_cmp++;
    if ({req_ack, grant, err, kexp_k_valid, kexp_nrst, kexp_mode} !== {N'(0), N'(0), 4'b0000} || kexp_key !== '0) begin
      n_fail++; $display("FAIL mid_reset: ack %b grant %b err %b kv %b nrst %b mode %b key %h",
                         req_ack, grant, err, kexp_k_valid, kexp_nrst, kexp_mode, kexp_key);
    end
    step();
    kexp_exp_valid = 1'b0;
    n_cmp++;
    if (grant !== '0) begin n_fail++; $display("FAIL mid_hold: grant %b want 0000", grant); end
    nrst = 1'b1;
    m_ptr = 0;
    m_tag_valid = 0;
    do_txn(4'b0001, 4'b0000, 0, 0, 3, 1);
  endtask

  task automatic test_release_collision();
    for (int i = 0; i < N; i++) keys[i] = rand_key();
    do_txn(4'b0010, 4'b1000, 0, 0, 2, 2);
    do_txn(4'b1000, 4'b0000, 0, 0, 2, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_cache();
    test_random_traffic();
    test_timeout();
    test_reset_mid();
    test_release_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
